zap_tlb_lookup_fill: RTL and testbench
======================================

ZAP_TLB_LOOKUP_FILL -- requirements
Module: zap_tlb_lookup_fill

Interface
REQ-001 SHALL have parameter DEPTH, default 32: number of direct-mapped entries, a power of two ≥ 2.
REQ-002 SHALL have parameter FRAME_W, default 20: physical frame width for 4 KB pages.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 SHALL have port i_inv, input, 1 bit: a one-cycle pulse that invalidates all entries.
REQ-006 SHALL have ports i_req_valid (input, 1 bit), o_req_ready (output, 1 bit) and i_va (input, 32 bits): the lookup request handshake and its virtual address.
REQ-007 SHALL have ports o_rsp_valid (output, 1 bit), o_pa (output, 32 bits) and o_fault (output, 1 bit): the response, presented as a one-cycle pulse with no backpressure.
REQ-008 SHALL have ports o_walk_req (output, 1 bit), o_walk_va (output, 32 bits), i_walk_ack (input, 1 bit), i_walk_frame (input, FRAME_W bits) and i_walk_fault (input, 1 bit): the page-walk handshake.

Function
REQ-009 SHALL use these address fields: index = i_va[12+IDX-1:12], where IDX = clog2(DEPTH); tag = i_va[31:12+IDX]; offset = i_va[11:0].
REQ-010 SHALL store each entry as {tag, frame}, so the entry width is (20-IDX)+FRAME_W bits.
REQ-011 SHALL have FSM states IDLE, RD, CMP, WALK and FILL.
REQ-012 SHALL assert o_req_ready only in IDLE; a request is accepted when i_req_valid & o_req_ready, the VA is latched and the state moves to RD.
REQ-013 RD SHALL drive the tag RAM read address with the latched index; the next state is CMP.
REQ-014 CMP SHALL declare a hit when rdav=1 and the stored tag equals the latched tag, and a miss otherwise.
REQ-015 On a hit, CMP SHALL register o_rsp_valid=1, o_pa={frame, offset} and o_fault=0, then return to IDLE; the response is visible 2 edges after the accept edge.
REQ-016 On a miss, CMP SHALL move to WALK and register o_walk_req=1 with o_walk_va equal to the latched VA.
REQ-017 WALK SHALL hold o_walk_req and o_walk_va stable until i_walk_ack; i_walk_frame and i_walk_fault are sampled only on the ack edge.
REQ-018 On an ack without fault, the FSM SHALL deassert o_walk_req, register the response {i_walk_frame, offset} with o_fault=0, and move to FILL.
REQ-019 FILL SHALL assert the RAM write enable for exactly one cycle at the latched index with {tag, frame}, then go to IDLE.
REQ-020 On an ack with fault, the FSM SHALL register o_rsp_valid=1, o_fault=1 and o_pa=0, perform no fill, and go to IDLE.
REQ-021 An i_inv that arrives during RD or CMP SHALL force the outcome of that lookup to be a miss.
REQ-022 An i_inv that arrives during WALK or FILL SHALL suppress the pending fill write, while the walk response is still delivered.
REQ-023 An i_inv in any cycle SHALL clear all valid bits so that they are invalid from the next edge.
REQ-024 An i_inv coincident with the FILL write SHALL take priority, leaving the entry invalid.
REQ-025 A fill to an index that already holds a different tag SHALL overwrite that entry.
REQ-026 o_rsp_valid SHALL never be high for two consecutive cycles.

Reset
REQ-027 While i_reset_n=0, the block SHALL asynchronously force: state=IDLE; o_req_ready=0; o_rsp_valid=0; o_pa=0; o_fault=0; o_walk_req=0; o_walk_va=0.
REQ-028 All entries SHALL be invalid after reset; the sub-block's synchronous reset is driven by !i_reset_n.
REQ-029 A reset during WALK SHALL abandon the walk, and a late i_walk_ack received in IDLE SHALL be ignored.
REQ-030 o_req_ready SHALL rise on the first clock edge after reset deasserts.

Structure
REQ-031 The FSM state enum and the constants PAGE_SHIFT=12 and VA_W=32 SHALL live in the shared zap package.
REQ-032 The block SHALL instantiate exactly one zap_mem_inv_block, with WIDTH=(20-IDX)+FRAME_W and DEPTH=DEPTH, as its tag store.

Verification
REQ-033 The bench SHALL cover cold miss: va=0x0000_3ABC, walk ack with frame=0x12345 -> o_walk_va=0x0000_3ABC, o_pa=0x1234_5ABC, o_fault=0, one fill at index 3.
REQ-034 The bench SHALL cover hit: repeat va=0x0000_3ABC -> o_rsp_valid 2 edges after accept, o_pa=0x1234_5ABC, o_walk_req never asserted.
REQ-035 The bench SHALL cover alias: va=0x0002_3ABC (index 3, tag 1), frame=0x0AAAA -> miss then o_pa=0x0AAA_AABC; then va=0x0000_3ABC -> miss again.
REQ-036 The bench SHALL cover fault: walk ack with fault=1 -> o_fault=1, o_pa=0, no write; the same VA re-requested -> a new walk.
REQ-037 The bench SHALL cover invalidate mid-walk: i_inv pulse while in WALK, ack frame=0x00055 -> o_pa=0x0005_5ABC delivered; the next lookup of the same VA misses.
REQ-038 The bench SHALL cover reset mid-walk: i_reset_n low during WALK -> all outputs 0 immediately, a subsequent ack is ignored, and a later lookup misses.

Source files
------------

// File: rtl/zap_pkg.sv
// Shared definitions for the zap TLB: address geometry and the lookup FSM states.
package zap_pkg;
    localparam int PAGE_SHIFT = 12;
    localparam int VA_W       = 32;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CMP,
        WALK,
        FILL
    } zap_state_e;
endpackage

// File: rtl/zap_mem_inv_block.sv
// Direct-mapped entry store with a per-entry valid bit and a one-shot flash invalidate.
module zap_mem_inv_block #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_inv,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic                     o_rdav,
    output logic [WIDTH-1:0]         o_rd_data,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data
);
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [WIDTH-1:0] ram_q [DEPTH];
    logic             rdav_q;
    logic [WIDTH-1:0] rd_data_q;

    // Flash invalidate wins over a coincident write.
    always_comb begin
        valid_d = valid_q;
        if (i_wr_en) begin
            valid_d[i_wr_addr] = 1'b1;
        end
        if (i_inv) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= '0;
            rdav_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            rdav_q  <= valid_q[i_rd_addr] & ~i_inv;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_wr_en && !i_inv) begin
            ram_q[i_wr_addr] <= i_wr_data;
        end
        rd_data_q <= ram_q[i_rd_addr];
    end

    assign o_rdav    = rdav_q;
    assign o_rd_data = rd_data_q;
endmodule

// File: rtl/zap_tlb_lookup_fill.sv
// Direct-mapped TLB: registered lookup, page-walk on miss, fill on successful walk.
module zap_tlb_lookup_fill
    import zap_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int FRAME_W = 20
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_inv,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic [VA_W-1:0]    i_va,
    output logic               o_rsp_valid,
    output logic [VA_W-1:0]    o_pa,
    output logic               o_fault,
    output logic               o_walk_req,
    output logic [VA_W-1:0]    o_walk_va,
    input  logic               i_walk_ack,
    input  logic [FRAME_W-1:0] i_walk_frame,
    input  logic               i_walk_fault
);
    localparam int IDX   = $clog2(DEPTH);
    localparam int TAG_W = VA_W - PAGE_SHIFT - IDX;
    localparam int ENT_W = TAG_W + FRAME_W;

    zap_state_e         state_q;
    logic [VA_W-1:0]    va_q;
    logic               req_ready_q;
    logic               rsp_valid_q;
    logic [VA_W-1:0]    pa_q;
    logic               fault_q;
    logic               walk_req_q;
    logic [VA_W-1:0]    walk_va_q;
    logic [FRAME_W-1:0] fill_frame_q;
    logic               fill_kill_q;

    logic [IDX-1:0]        idx;
    logic [TAG_W-1:0]      tag;
    logic [PAGE_SHIFT-1:0] offset;
    logic                  rdav;
    logic [ENT_W-1:0]      rd_ent;
    logic                  wr_en;
    logic                  hit;

    function automatic logic [VA_W-1:0] make_pa(input logic [FRAME_W-1:0] frame,
                                                input logic [PAGE_SHIFT-1:0] off);
        logic [FRAME_W+PAGE_SHIFT-1:0] full;
        full = {frame, off};
        return VA_W'(full);
    endfunction

    assign idx    = va_q[PAGE_SHIFT +: IDX];
    assign tag    = va_q[VA_W-1 -: TAG_W];
    assign offset = va_q[PAGE_SHIFT-1:0];
    assign wr_en  = (state_q == FILL) && !fill_kill_q;
    // An invalidate landing in the compare cycle must not let a stale entry hit.
    assign hit    = rdav && !i_inv && (rd_ent[ENT_W-1 -: TAG_W] == tag);

    zap_mem_inv_block #(
        .WIDTH(ENT_W),
        .DEPTH(DEPTH)
    ) u_tags (
        .i_clk    (i_clk),
        .i_rst    (!i_reset_n),
        .i_inv    (i_inv),
        .i_rd_addr(idx),
        .o_rdav   (rdav),
        .o_rd_data(rd_ent),
        .i_wr_en  (wr_en),
        .i_wr_addr(idx),
        .i_wr_data({tag, fill_frame_q})
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= IDLE;
            va_q         <= '0;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            pa_q         <= '0;
            fault_q      <= 1'b0;
            walk_req_q   <= 1'b0;
            walk_va_q    <= '0;
            fill_frame_q <= '0;
            fill_kill_q  <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (i_req_valid && req_ready_q) begin
                        va_q        <= i_va;
                        req_ready_q <= 1'b0;
                        state_q     <= RD;
                    end
                end
                RD: state_q <= CMP;
                CMP: begin
                    if (hit) begin
                        rsp_valid_q <= 1'b1;
                        pa_q        <= make_pa(rd_ent[FRAME_W-1:0], offset);
                        fault_q     <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        walk_req_q  <= 1'b1;
                        walk_va_q   <= va_q;
                        fill_kill_q <= 1'b0;
                        state_q     <= WALK;
                    end
                end
                WALK: begin
                    if (i_inv) begin
                        fill_kill_q <= 1'b1;
                    end
                    if (i_walk_ack) begin
                        walk_req_q  <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        if (i_walk_fault) begin
                            pa_q        <= '0;
                            fault_q     <= 1'b1;
                            req_ready_q <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            pa_q         <= make_pa(i_walk_frame, offset);
                            fault_q      <= 1'b0;
                            fill_frame_q <= i_walk_frame;
                            state_q      <= FILL;
                        end
                    end
                end
                FILL: begin
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_req_ready = req_ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_pa        = pa_q;
    assign o_fault     = fault_q;
    assign o_walk_req  = walk_req_q;
    assign o_walk_va   = walk_va_q;
endmodule

// File: tb/tb_zap_tlb_lookup_fill.sv
// Directed and randomized lookups checked against an array-based TLB model.
module tb_zap_tlb_lookup_fill;
    localparam int DEPTH   = 32;
    localparam int FRAME_W = 20;

    logic               i_clk = 1'b0;
    logic               i_reset_n = 1'b1;
    logic               i_inv = 1'b0;
    logic               i_req_valid = 1'b0;
    logic               o_req_ready;
    logic [31:0]        i_va = '0;
    logic               o_rsp_valid;
    logic [31:0]        o_pa;
    logic               o_fault;
    logic               o_walk_req;
    logic [31:0]        o_walk_va;
    logic               i_walk_ack = 1'b0;
    logic [FRAME_W-1:0] i_walk_frame = '0;
    logic               i_walk_fault = 1'b0;

    int checks = 0;
    int failures = 0;

    bit          m_valid [DEPTH];
    int unsigned m_tag   [DEPTH];
    logic [19:0] m_frame [DEPTH];

    zap_tlb_lookup_fill #(.DEPTH(DEPTH), .FRAME_W(FRAME_W)) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_inv       (i_inv),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_va        (i_va),
        .o_rsp_valid (o_rsp_valid),
        .o_pa        (o_pa),
        .o_fault     (o_fault),
        .o_walk_req  (o_walk_req),
        .o_walk_va   (o_walk_va),
        .i_walk_ack  (i_walk_ack),
        .i_walk_frame(i_walk_frame),
        .i_walk_fault(i_walk_fault)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", nm, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic model_inv();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, "_ready"}, {31'b0, o_req_ready}, 32'd0);
        check({nm, "_rsp"},   {31'b0, o_rsp_valid}, 32'd0);
        check({nm, "_pa"},    o_pa, 32'd0);
        check({nm, "_fault"}, {31'b0, o_fault}, 32'd0);
        check({nm, "_wreq"},  {31'b0, o_walk_req}, 32'd0);
        check({nm, "_wva"},   o_walk_va, 32'd0);
    endtask

    task automatic wait_ready(input string nm);
        int waited = 0;
        while (!o_req_ready && waited < 20) begin
            tick();
            waited++;
        end
        check({nm, "_ready"}, {31'b0, o_req_ready}, 32'd1);
    endtask

    // inv_when: 0 none, 1 during RD, 2 during CMP, 3 during WALK
    task automatic lookup(input logic [31:0] va, input logic [19:0] frame, input bit fault,
                          input int inv_when, input string nm);
        int          idx = int'((va >> 12) % DEPTH);
        int unsigned tg  = va >> 17;
        bit          exp_hit;
        int          n;
        logic [31:0] exp_pa;
        wait_ready(nm);
        exp_hit = m_valid[idx] && (m_tag[idx] == tg) && inv_when != 1 && inv_when != 2;
        i_req_valid = 1'b1;
        i_va = va;
        tick();
        i_req_valid = 1'b0;
        if (inv_when == 1) begin
            i_inv = 1'b1;
            model_inv();
        end
        tick();
        i_inv = 1'b0;
        check({nm, "_rsp_early"}, {31'b0, o_rsp_valid}, 32'd0);
        if (inv_when == 2) begin
            i_inv = 1'b1;
            model_inv();
        end
        tick();
        i_inv = 1'b0;
        if (exp_hit) begin
            check({nm, "_hit_rsp"},   {31'b0, o_rsp_valid}, 32'd1);
            check({nm, "_hit_pa"},    o_pa, {m_frame[idx], va[11:0]});
            check({nm, "_hit_fault"}, {31'b0, o_fault}, 32'd0);
            check({nm, "_hit_wreq"},  {31'b0, o_walk_req}, 32'd0);
            tick();
            check({nm, "_hit_pulse"}, {31'b0, o_rsp_valid}, 32'd0);
            return;
        end
        check({nm, "_miss_wreq"}, {31'b0, o_walk_req}, 32'd1);
        check({nm, "_miss_wva"},  o_walk_va, va);
        check({nm, "_miss_rsp"},  {31'b0, o_rsp_valid}, 32'd0);
        n = int'($urandom_range(0, 3));
        if (inv_when == 3 && n == 0) n = 1;
        for (int k = 0; k < n; k++) begin
            if (inv_when == 3 && k == 0) begin
                i_inv = 1'b1;
                model_inv();
            end
            tick();
            i_inv = 1'b0;
            check({nm, "_hold_wreq"}, {31'b0, o_walk_req}, 32'd1);
            check({nm, "_hold_wva"},  o_walk_va, va);
        end
        i_walk_ack = 1'b1;
        i_walk_frame = frame;
        i_walk_fault = fault;
        tick();
        i_walk_ack = 1'b0;
        i_walk_fault = 1'b0;
        i_walk_frame = FRAME_W'($urandom);
        exp_pa = fault ? 32'd0 : {frame, va[11:0]};
        check({nm, "_walk_rsp"},   {31'b0, o_rsp_valid}, 32'd1);
        check({nm, "_walk_pa"},    o_pa, exp_pa);
        check({nm, "_walk_fault"}, {31'b0, o_fault}, {31'b0, fault});
        check({nm, "_walk_wreq"},  {31'b0, o_walk_req}, 32'd0);
        if (!fault && inv_when != 3) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_frame[idx] = frame;
        end
        tick();
        check({nm, "_walk_pulse"}, {31'b0, o_rsp_valid}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] va;
        int          r;
        int          inv_when;
        model_inv();
        #1 i_reset_n = 1'b0;
        #2;
        check_idle_outputs("rst_async");
        tick();
        tick();
        tick();
        check_idle_outputs("rst_hold");
        #2 i_reset_n = 1'b1;
        #1;
        check("rst_rel_ready_lo", {31'b0, o_req_ready}, 32'd0);
        tick();
        check("rst_rel_ready_hi", {31'b0, o_req_ready}, 32'd1);

        lookup(32'h0000_3ABC, 20'h12345, 1'b0, 0, "cold");
        lookup(32'h0000_3ABC, 20'h0BEEF, 1'b0, 0, "hit");
        lookup(32'h0002_3ABC, 20'h0AAAA, 1'b0, 0, "alias");
        lookup(32'h0000_3ABC, 20'h12345, 1'b0, 0, "realias");
        lookup(32'h0000_5123, 20'h11111, 1'b1, 0, "fault");
        lookup(32'h0000_5123, 20'h22222, 1'b0, 0, "refetch");
        lookup(32'h0000_5123, 20'h33333, 1'b0, 0, "refetch_hit");
        lookup(32'h0000_7ABC, 20'h00055, 1'b0, 3, "invwalk");
        lookup(32'h0000_7ABC, 20'h00066, 1'b0, 0, "postinv");
        lookup(32'h0000_7ABC, 20'h00077, 1'b0, 1, "invrd");
        lookup(32'h0000_7ABC, 20'h00088, 1'b0, 2, "invcmp");
        lookup(32'h0000_7ABC, 20'h00099, 1'b0, 0, "invcmp_hit");

        // reset in the middle of a walk
        wait_ready("rstwalk");
        i_req_valid = 1'b1;
        i_va = 32'h0004_9000;
        tick();
        i_req_valid = 1'b0;
        tick();
        tick();
        check("rstwalk_wreq", {31'b0, o_walk_req}, 32'd1);
        #2 i_reset_n = 1'b0;
        #1;
        model_inv();
        check_idle_outputs("rstwalk_async");
        tick();
        tick();
        #2 i_reset_n = 1'b1;
        tick();
        check("rstwalk_ready", {31'b0, o_req_ready}, 32'd1);
        i_walk_ack = 1'b1;
        i_walk_frame = 20'h44444;
        tick();
        i_walk_ack = 1'b0;
        check("late_ack_rsp",  {31'b0, o_rsp_valid}, 32'd0);
        check("late_ack_wreq", {31'b0, o_walk_req}, 32'd0);
        tick();
        check("late_ack_rsp2", {31'b0, o_rsp_valid}, 32'd0);
        lookup(32'h0000_3ABC, 20'h12345, 1'b0, 0, "after_rst");

        for (int t = 0; t < 80; t++) begin
            va = (32'($urandom_range(0, 2)) << 17) | (32'($urandom_range(0, DEPTH - 1)) << 12)
                 | 32'($urandom_range(0, 4095));
            r = int'($urandom_range(0, 19));
            inv_when = (r < 3) ? r + 1 : 0;
            lookup(va, 20'($urandom), ($urandom_range(0, 7) == 0), inv_when, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
